// File: rtl/samp_iter_multi.sv
// samp_iter_multi: walks a triangle's bounding box in raster order, SAMPS sample positions per cycle.
// Optional macro SAMP_ITER_BACK_TO_BACK_EN: accept the next triangle during the final TEST cycle.
module samp_iter_multi #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS],
  output logic        [SAMPS-1:0]  validSamp_R14H
);

  localparam int unsigned W1 = SIGFIG + 1;
  localparam logic [SIGFIG-1:0] ONE_PX = SIGFIG'(1) << RADIX;

  typedef enum logic {WAIT, TEST} state_t;

  state_t                   state_q, state_d;
  logic signed [SIGFIG-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic signed [SIGFIG-1:0] ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
  logic signed [SIGFIG-1:0] step_q, step_d, step_in;
  logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
  logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q [COLORS];
  logic        [SIGFIG-1:0] color_d [COLORS];

  logic signed [W1-1:0] cur_x_w, cur_y_w, ur_x_w, ur_y_w, step_w, nx_w, ny_w;
  logic signed [W1-1:0] lane_x_w [SAMPS];
  logic                 last_c, box_ok_c, accept_c;

  // Subsample step decode; anything but one-hot leaves step at zero.
  always_comb begin
    step_in = '0;
    case (subSample_RnnnnU)
      4'b1000: step_in = ONE_PX;
      4'b0100: step_in = ONE_PX >> 1;
      4'b0010: step_in = ONE_PX >> 2;
      4'b0001: step_in = ONE_PX >> 3;
      default: step_in = '0;
    endcase
  end

  // Widened arithmetic so a wrap past max positive compares as out of box.
  assign cur_x_w  = W1'(cur_x_q);
  assign cur_y_w  = W1'(cur_y_q);
  assign ur_x_w   = W1'(ur_x_q);
  assign ur_y_w   = W1'(ur_y_q);
  assign step_w   = W1'(step_q);
  assign nx_w     = cur_x_w + W1'(SAMPS) * step_w;
  assign ny_w     = cur_y_w + step_w;
  assign last_c   = (state_q == TEST) && (nx_w > ur_x_w) && (ny_w > ur_y_w);
  assign box_ok_c = (box_R13S[1][0] >= box_R13S[0][0]) && (box_R13S[1][1] >= box_R13S[0][1]);

`ifdef SAMP_ITER_BACK_TO_BACK_EN
  assign halt_RnnnnL = (state_q == WAIT) || last_c;
`else
  assign halt_RnnnnL = (state_q == WAIT);
`endif
  assign accept_c = validTri_R13H && halt_RnnnnL;

  always_comb begin
    for (int k = 0; k < SAMPS; k++) begin
      lane_x_w[k]          = cur_x_w + W1'(k) * step_w;
      sample_R14S[0][k]    = SIGFIG'(lane_x_w[k]);
      sample_R14S[1][k]    = cur_y_q;
      validSamp_R14H[k]    = (state_q == TEST) && (lane_x_w[k] <= ur_x_w);
    end
  end

  assign tri_R14S   = tri_q;
  assign color_R14U = color_q;

  // Next-state: advance the raster walk, then let an accepted triangle override it.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    ll_x_d  = ll_x_q;
    ur_x_d  = ur_x_q;
    ur_y_d  = ur_y_q;
    step_d  = step_q;
    tri_d   = tri_q;
    color_d = color_q;

    if (state_q == TEST) begin
      if (nx_w <= ur_x_w) begin
        cur_x_d = SIGFIG'(nx_w);
      end else if (ny_w <= ur_y_w) begin
        cur_x_d = ll_x_q;
        cur_y_d = SIGFIG'(ny_w);
      end else begin
        state_d = WAIT;
      end
    end

    if (accept_c && box_ok_c) begin
      state_d = TEST;
      cur_x_d = box_R13S[0][0];
      cur_y_d = box_R13S[0][1];
      ll_x_d  = box_R13S[0][0];
      ur_x_d  = box_R13S[1][0];
      ur_y_d  = box_R13S[1][1];
      step_d  = step_in;
      tri_d   = tri_R13S;
      color_d = color_R13U;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      cur_x_q <= '0;
      cur_y_q <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      step_q  <= '0;
      tri_q   <= '{default: '0};
      color_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      ll_x_q  <= ll_x_d;
      ur_x_q  <= ur_x_d;
      ur_y_q  <= ur_y_d;
      step_q  <= step_d;
      tri_q   <= tri_d;
      color_q <= color_d;
    end
  end

  // Subsample width must be one-hot whenever a triangle is taken.
  always @(posedge clk) begin
    if (!rst && accept_c) assert ($onehot(subSample_RnnnnU));
  end

endmodule

// File: tb/tb_samp_iter_multi.sv
// Self-checking bench for samp_iter_multi against a raster-walk reference model.
module tb_samp_iter_multi;
  localparam int SIGFIG = 24, RADIX = 10, VERTS = 3, AXIS = 3, COLORS = 3, SAMPS = 4;
  localparam int TW = VERTS*AXIS*SIGFIG;
  localparam int CW = COLORS*SIGFIG;
  localparam int OW = SAMPS + 1 + 2*SAMPS*SIGFIG;
`ifdef SAMP_ITER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [SIGFIG-1:0] tri_in [VERTS][AXIS];
  logic        [SIGFIG-1:0] col_in [COLORS];
  logic signed [SIGFIG-1:0] box_in [2][2];
  logic                     valid_in = 1'b0;
  logic        [3:0]        sub_in = 4'b1000;
  logic                     halt_RnnnnL;
  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS];
  logic        [SAMPS-1:0]  validSamp_R14H;

  always #5 clk = ~clk;

  samp_iter_multi #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS),
                    .COLORS(COLORS), .SAMPS(SAMPS)) dut (
    .clk(clk), .rst(rst), .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box_in),
    .validTri_R13H(valid_in), .subSample_RnnnnU(sub_in), .halt_RnnnnL(halt_RnnnnL),
    .tri_R14S(tri_R14S), .color_R14U(color_R14U), .sample_R14S(sample_R14S),
    .validSamp_R14H(validSamp_R14H)
  );

  typedef struct {
    logic [SAMPS-1:0] vmask;
    logic             halt;
    longint           x0, y, step;
  } cyc_t;

  cyc_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic [TW+CW-1:0] exp_tri;

  function automatic longint step_of(input logic [3:0] sub);
    case (sub)
      4'b1000: return longint'(1) << RADIX;
      4'b0100: return longint'(1) << (RADIX-1);
      4'b0010: return longint'(1) << (RADIX-2);
      default: return longint'(1) << (RADIX-3);
    endcase
  endfunction

  // Reference: every group the raster walk of one box produces, in order.
  function automatic void model_tri(input longint llx, lly, urx, ury, stp);
    cyc_t c;
    if (urx < llx || ury < lly) return;
    for (longint y = lly; y <= ury; y += stp)
      for (longint x = llx; x <= urx; x += SAMPS*stp) begin
        c.x0 = x; c.y = y; c.step = stp; c.halt = 1'b0;
        for (int k = 0; k < SAMPS; k++) c.vmask[k] = (x + longint'(k)*stp <= urx);
        exp_q.push_back(c);
      end
    if (B2B) exp_q[exp_q.size()-1].halt = 1'b1;
  endfunction

  function automatic void model_bubble();
    cyc_t c;
    c = exp_q[exp_q.size()-1];
    c.vmask = '0;
    c.halt = 1'b1;
    exp_q.push_back(c);
  endfunction

  function automatic logic [OW-1:0] exp_vec(input cyc_t c);
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < SAMPS; k++) begin
      v[k*SIGFIG +: SIGFIG]         = SIGFIG'(c.x0 + longint'(k)*c.step);
      v[(SAMPS+k)*SIGFIG +: SIGFIG] = SIGFIG'(c.y);
    end
    v[OW-1 -: SAMPS+1] = {c.vmask, c.halt};
    return v;
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < SAMPS; k++) begin
      v[k*SIGFIG +: SIGFIG]         = sample_R14S[0][k];
      v[(SAMPS+k)*SIGFIG +: SIGFIG] = sample_R14S[1][k];
    end
    v[OW-1 -: SAMPS+1] = {validSamp_R14H, halt_RnnnnL};
    return v;
  endfunction

  function automatic logic [TW+CW-1:0] tri_vec();
    logic [TW+CW-1:0] v;
    v = '0;
    for (int i = 0; i < VERTS; i++)
      for (int a = 0; a < AXIS; a++) v[(i*AXIS+a)*SIGFIG +: SIGFIG] = tri_R14S[i][a];
    for (int c = 0; c < COLORS; c++) v[TW + c*SIGFIG +: SIGFIG] = color_R14U[c];
    return v;
  endfunction

  task automatic drive_tri(input longint llx, lly, urx, ury);
    exp_tri = '0;
    for (int i = 0; i < VERTS; i++)
      for (int a = 0; a < AXIS; a++) begin
        tri_in[i][a] = SIGFIG'($urandom);
        exp_tri[(i*AXIS+a)*SIGFIG +: SIGFIG] = tri_in[i][a];
      end
    for (int c = 0; c < COLORS; c++) begin
      col_in[c] = SIGFIG'($urandom);
      exp_tri[TW + c*SIGFIG +: SIGFIG] = col_in[c];
    end
    box_in[0][0] = SIGFIG'(llx); box_in[0][1] = SIGFIG'(lly);
    box_in[1][0] = SIGFIG'(urx); box_in[1][1] = SIGFIG'(ury);
  endtask

  task automatic test_reset();
    cyc_t z;
    z.vmask = '0; z.halt = 1'b1; z.x0 = 0; z.y = 0; z.step = 0;
    drive_tri(0, 0, 0, 0);
    #2;
    n_checks++;
    if (obs_vec() !== exp_vec(z)) $display("FAIL reset_outputs: got %h want %h", obs_vec(), exp_vec(z));
    else n_pass++;
    n_checks++;
    if (tri_vec() !== '0) $display("FAIL reset_tri: got %h want 0", tri_vec());
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  // Plan cases plus a box sitting at max positive x, and an inverted box in each axis.
  task automatic test_directed();
    logic [3:0] subs [7]   = '{4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b1000, 4'b1000, 4'b1000};
    longint     boxes [7][4] = '{'{0, 0, 3072, 1024}, '{0, 0, 2048, 0}, '{0, 0, 5120, 0},
                                 '{256, 512, 512, 512}, '{8387584, 0, 8387584, 0},
                                 '{2048, 0, 1024, 0}, '{0, 1024, 0, 0}};
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      sub_in = subs[t];
      drive_tri(boxes[t][0], boxes[t][1], boxes[t][2], boxes[t][3]);
      valid_in = 1'b1;
      exp_q.delete();
      model_tri(boxes[t][0], boxes[t][1], boxes[t][2], boxes[t][3], step_of(subs[t]));
      @(negedge clk); valid_in = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i == 0) begin
          n_checks++;
          if (tri_vec() !== exp_tri) $display("FAIL directed_tri case %0d: got %h want %h", t, tri_vec(), exp_tri);
          else n_pass++;
        end
        n_checks++;
        if (obs_vec() !== exp_vec(exp_q[i]))
          $display("FAIL directed case %0d cyc %0d: got %h want %h", t, i, obs_vec(), exp_vec(exp_q[i]));
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if ({validSamp_R14H, halt_RnnnnL} !== {SAMPS'(0), 1'b1})
        $display("FAIL directed_idle case %0d: got %b want %b", t, {validSamp_R14H, halt_RnnnnL}, {SAMPS'(0), 1'b1});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    longint stp, llx, lly, urx, ury;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      sub_in = 4'(1 << $urandom_range(0, 3));
      stp = step_of(sub_in);
      llx = longint'(int'($urandom_range(0, 64)) - 32) * stp;
      lly = longint'(int'($urandom_range(0, 64)) - 32) * stp;
      urx = llx + longint'(int'($urandom_range(0, 12)) - 1) * stp;
      ury = lly + longint'($urandom_range(0, 3)) * stp;
      drive_tri(llx, lly, urx, ury);
      valid_in = 1'b1;
      exp_q.delete();
      model_tri(llx, lly, urx, ury, stp);
      @(negedge clk); valid_in = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i == 0) begin
          n_checks++;
          if (tri_vec() !== exp_tri) $display("FAIL random_tri iter %0d: got %h want %h", t, tri_vec(), exp_tri);
          else n_pass++;
        end
        n_checks++;
        if (obs_vec() !== exp_vec(exp_q[i]))
          $display("FAIL random iter %0d cyc %0d: got %h want %h", t, i, obs_vec(), exp_vec(exp_q[i]));
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if ({validSamp_R14H, halt_RnnnnL} !== {SAMPS'(0), 1'b1})
        $display("FAIL random_idle iter %0d: got %b want %b", t, {validSamp_R14H, halt_RnnnnL}, {SAMPS'(0), 1'b1});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    cyc_t z;
    z.vmask = '0; z.halt = 1'b1; z.x0 = 0; z.y = 0; z.step = 0;
    @(negedge clk);
    sub_in = 4'b1000;
    drive_tri(0, 0, 1024, 2048);
    valid_in = 1'b1;
    exp_q.delete();
    model_tri(0, 0, 1024, 2048, 1024);
    @(negedge clk); valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(exp_q[i]))
        $display("FAIL reset_mid pre cyc %0d: got %h want %h", i, obs_vec(), exp_vec(exp_q[i]));
      else n_pass++;
      if (i == 0) @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec(z)) $display("FAIL reset_mid async: got %h want %h", obs_vec(), exp_vec(z));
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    sub_in = 4'b0100;
    drive_tri(2048, 1024, 4096, 1024);
    valid_in = 1'b1;
    exp_q.delete();
    model_tri(2048, 1024, 4096, 1024, 512);
    @(negedge clk); valid_in = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(exp_q[i]))
        $display("FAIL reset_mid post cyc %0d: got %h want %h", i, obs_vec(), exp_vec(exp_q[i]));
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({validSamp_R14H, halt_RnnnnL} !== {SAMPS'(0), 1'b1})
      $display("FAIL reset_mid idle: got %b want %b", {validSamp_R14H, halt_RnnnnL}, {SAMPS'(0), 1'b1});
    else n_pass++;
  endtask

  // Upstream holds the second triangle valid while the first is iterated.
  task automatic test_back_to_back();
    logic [TW+CW-1:0] tri_a, tri_b;
    int nb;
    @(negedge clk);
    sub_in = 4'b1000;
    drive_tri(0, 0, 1024, 1024);
    tri_a = exp_tri;
    valid_in = 1'b1;
    exp_q.delete();
    model_tri(0, 0, 1024, 1024, 1024);
    if (!B2B) model_bubble();
    nb = exp_q.size();
    model_tri(-2048, -1024, -1024, -1024, 1024);
    @(negedge clk);
    drive_tri(-2048, -1024, -1024, -1024);
    tri_b = exp_tri;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == nb) valid_in = 1'b0;
      if (i == 0 || i == nb) begin
        n_checks++;
        if (tri_vec() !== ((i == 0) ? tri_a : tri_b))
          $display("FAIL b2b_tri cyc %0d: got %h want %h", i, tri_vec(), (i == 0) ? tri_a : tri_b);
        else n_pass++;
      end
      n_checks++;
      if (obs_vec() !== exp_vec(exp_q[i]))
        $display("FAIL b2b cyc %0d: got %h want %h", i, obs_vec(), exp_vec(exp_q[i]));
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({validSamp_R14H, halt_RnnnnL} !== {SAMPS'(0), 1'b1})
      $display("FAIL b2b_idle: got %b want %b", {validSamp_R14H, halt_RnnnnL}, {SAMPS'(0), 1'b1});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/samp_iter_multi.md
Name: samp_iter_multi

Overview:
- Sample iterator that feeds the jitter/hash stage with SAMPS candidate sample positions per cycle.
- Accepts one bounding-boxed triangle (R13) from the bbox stage.
- Walks the box in raster order (x fastest, then y) at the subsample step.
- Emits triangle, colour, sample positions and per-lane valids at R14.
- Stalls the bbox stage with an active-low halt while a triangle is being iterated.

Parameters:
SIGFIG, 24, fixed-point word width
RADIX, 10, fractional bits (1 pixel = 1<<RADIX)
VERTS, 3, triangle vertices
AXIS, 3, coordinates per vertex
COLORS, 3, colour channels
SAMPS, 4, sample lanes per cycle (power of 2, 1..8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
tri_R13S  in  signed SIGFIG [VERTS][AXIS]  triangle
color_R13U  in  SIGFIG [COLORS]  triangle colour
box_R13S  in  signed SIGFIG [2][2]  [0]=lower-left (x,y), [1]=upper-right (x,y), pixel/subsample-aligned
validTri_R13H  in  1  triangle and box valid
subSample_RnnnnU  in  4  one-hot subsample width
halt_RnnnnL  out  1  low = upstream must hold R13 inputs
tri_R14S  out  signed SIGFIG [VERTS][AXIS]  captured triangle
color_R14U  out  SIGFIG [COLORS]  captured colour
sample_R14S  out  signed SIGFIG [2][SAMPS]  sample positions; [0]=x, [1]=y
validSamp_R14H  out  1 [SAMPS]  per-lane sample valid

Behaviour:
- Step size from subSample_RnnnnU:
  - [3] -> 1<<RADIX (MSAA 1)
  - [2] -> 1<<(RADIX-1) (MSAA 4)
  - [1] -> 1<<(RADIX-2) (MSAA 16)
  - [0] -> 1<<(RADIX-3) (MSAA 64)
  - Non-one-hot value is illegal; assert in simulation.
  - subSample_RnnnnU is static while any triangle is in flight.
- States: WAIT, TEST. halt_RnnnnL = (state==WAIT).
- WAIT:
  - Accept when validTri_R13H=1.
  - Capture tri, colour, box and step; cur_x=ll_x, cur_y=ll_y.
  - Go to TEST.
  - If ur_x<ll_x or ur_y<ll_y: discard, stay in WAIT, emit nothing.
- TEST, each cycle:
  - Lane k outputs x = cur_x + k*step, y = cur_y.
  - validSamp_R14H[k] = (x <= ur_x).
  - Lane 0 is always valid in TEST.
- Advance rule, nx = cur_x + SAMPS*step:
  - If nx <= ur_x: cur_x = nx.
  - Else: cur_x = ll_x, cur_y += step.
  - If new cur_y > ur_y: go to WAIT (the cycle that emitted the last group is the final TEST cycle).
- Arithmetic:
  - Compute additions at SIGFIG+1 bits, signed.
  - Comparisons on the widened value so wrap past max positive never reads as in-box.
- Outputs:
  - tri/colour/sample outputs come from registered state; lane offsets are combinational from registers.
  - Latency: triangle accepted on edge N, first sample group valid in cycle N+1.
  - Outputs in WAIT: validSamp_R14H all 0; tri/colour/sample hold last values.
- Throughput:
  - One group per cycle.
  - One bubble cycle (WAIT) between triangles.
- validTri_R13H in TEST is ignored; upstream holds it because halt_RnnnnL=0.
- Reset, asynchronous:
  - state=WAIT, halt_RnnnnL=1, validSamp_R14H=0.
  - sample_R14S, tri_R14S, color_R14U = 0.
  - Reset mid-TEST abandons the triangle; no further valids.

Optional Feature:
- Macro: SAMP_ITER_BACK_TO_BACK_EN.
- Defined:
  - halt_RnnnnL is also 1 during the final TEST cycle (advance would exit).
  - A validTri_R13H seen that cycle is captured; next state is TEST with the new triangle.
  - Zero-bubble handoff between triangles.
- Undefined: behaviour exactly as above (one bubble cycle).

Test Plan:
- Reset, then MSAA1 (subSample=4'b1000), SAMPS=4, box ll=(0,0) ur=(3072,1024) -> 2 TEST cycles.
  - Cycle 1: x={0,1024,2048,3072}, y=0, valids 1111.
  - Cycle 2: same x, y=1024, valids 1111.
  - halt_RnnnnL low for exactly 2 cycles.
- Box ll=(0,0) ur=(2048,0), MSAA1 -> single cycle, x={0,1024,2048,3072}, valids 0111 (lane3 invalid), then WAIT.
- Box ll=(0,0) ur=(5120,0), MSAA1 -> two groups:
  - x={0..3072} valids 1111.
  - x={4096,5120,6144,7168} valids 0011.
- MSAA16 (4'b0010), box ll=(256,512) ur=(512,512) -> one group x={256,512,768,1024}, y=512, valids 0011.
- Inverted box ur_x<ll_x -> halt_RnnnnL stays 1, no valids.
- Assert rst during a 3-row box in row 2 -> valids 0 and halt_RnnnnL=1 immediately.
  - A new triangle after release iterates from its own ll.
- Two back-to-back triangles:
  - Without SAMP_ITER_BACK_TO_BACK_EN: one valid-free cycle between them.
  - With it: zero gap.
